// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between uart_rx and uart_tx that releases one byte
// per transmitter handshake (tx_en out, tx_done back), with overflow and
// transmitter-timeout status.
module uart_tx_buffer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned TX_TIMEOUT = 131071
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_byte,
  input  logic          rx_done,
  output logic [7:0]    tx_byte,
  output logic          tx_en,
  input  logic          tx_done,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  output logic          tx_timeout,
  input  logic          clr_status
);

  localparam int unsigned DW = 8;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [DW-1:0]   tx_byte_q, tx_byte_d;
  logic            tx_en_q, tx_en_d;
  logic            overflow_q, overflow_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            tx_timeout_q, tx_timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            full_c;
  logic            wr_en_c;
  logic            rd_en_c;
  logic [DW-1:0]   drop_base_c;
  logic [CW-1:0]   cnt_inc_c;

  // Next-state: write/drop decision, transmit scheduler FSM, level and status
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    tx_byte_d    = tx_byte_q;
    tx_en_d      = 1'b0;
    cnt_d        = cnt_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    tx_timeout_d = tx_timeout_q;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    full_c       = (level_q == LW'(DEPTH));
    cnt_inc_c    = cnt_q + CW'(1);
    drop_base_c  = clr_status ? DW'(0) : drop_cnt_q;

    // status clear first so that a same-cycle event wins
    if (clr_status) begin
      overflow_d   = 1'b0;
      tx_timeout_d = 1'b0;
    end
    drop_cnt_d = drop_base_c;

    // a same-cycle read never frees room for a write into a full FIFO
    if (rx_done) begin
      if (full_c) begin
        overflow_d = 1'b1;
        if (drop_base_c != DW'(255)) begin
          drop_cnt_d = drop_base_c + DW'(1);
        end
      end else begin
        wr_en_c  = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (level_q != LW'(0)) begin
          rd_en_c   = 1'b1;
          tx_byte_d = mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + AW'(1);
          tx_en_d   = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = CW'(0);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CW'(TX_TIMEOUT)) begin
            tx_timeout_d = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case ({wr_en_c, rd_en_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      tx_byte_q    <= '0;
      tx_en_q      <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      tx_timeout_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      tx_byte_q    <= tx_byte_d;
      tx_en_q      <= tx_en_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      tx_timeout_q <= tx_timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_ptr_q] <= rx_byte;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_en      = tx_en_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
  assign tx_timeout = tx_timeout_q;

endmodule
